// File: rtl/param_alu.sv
// param_alu: parametrised ALU with single-cycle logic/arith ops and an iterative shift-add multiplier
module param_alu #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           op,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2*WIDTH-1:0]   result
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t          state_q, state_d;
  logic [RW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   result_q, result_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [RW-1:0]   step;
  assign step   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy   = state_q == MUL;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  // next state: decode commands in IDLE, one shift-add step per cycle in MUL
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        case (op)
          3'b001:  begin result_d = RW'(A) + RW'(B); done_d = 1'b1; end
          3'b010:  begin result_d = RW'(A & B);      done_d = 1'b1; end
          3'b011:  begin result_d = RW'(A ^ B);      done_d = 1'b1; end
          3'b100:  begin result_d = RW'(A | B);      done_d = 1'b1; end
          3'b101:  begin result_d = RW'(A) - RW'(B); done_d = 1'b1; end
          3'b110:  begin
            mcand_d  = RW'(A);
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end
          3'b111:  begin result_d = '0; done_d = 1'b1; err_d = 1'b1; end
          default: ;
        endcase
      end
    end else begin
      acc_d    = step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        result_d = step;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
    end
  end
  // state and output registers; reset aborts any multiply in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_param_alu.sv
// tb_param_alu: randomized and directed checks of param_alu against an arithmetic reference model
module tb_param_alu;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [2:0]  op8 = 0;
  logic        start8 = 0;
  logic        busy8, done8, err8;
  logic [15:0] res8;
  logic [15:0] a16 = 0, b16 = 0;
  logic [2:0]  op16 = 0;
  logic        start16 = 0;
  logic        busy16, done16, err16;
  logic [31:0] res16;
  int n_vec = 0, n_err = 0;
  logic [15:0] res_m = 0;

  param_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .op(op8), .start(start8),
    .busy(busy8), .done(done8), .err(err8), .result(res8)
  );
  param_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .op(op16), .start(start16),
    .busy(busy16), .done(done16), .err(err16), .result(res16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [2:0] o, input int a, input int b, input logic [15:0] prev);
    case (o)
      3'd1: return 16'(a + b);
      3'd2: return 16'(a & b);
      3'd3: return 16'(a ^ b);
      3'd4: return 16'(a | b);
      3'd5: return 16'(a - b + 65536);
      3'd6: return 16'(a * b);
      3'd7: return 16'd0;
      default: return prev;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input bit noisy);
    logic [15:0] exp;
    int k;
    exp = ref8(o, int'(a), int'(b), res_m);
    @(negedge clk);
    start8 = 1; op8 = o; a8 = a; b8 = b;
    @(negedge clk);
    if (o == 3'd6) begin
      start8 = noisy;
      op8 = 3'($urandom);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      chk("mul_busy", busy8, 1);
      chk("mul_early_done", done8, 0);
      chk("mul_hold", res8, res_m);
      k = 0;
      while (!done8 && k < 40) begin
        @(negedge clk);
        k++;
      end
      start8 = 0;
      chk("mul_latency", k, 8);
      chk("mul_busy_end", busy8, 0);
    end else begin
      start8 = 0;
    end
    chk("done", done8, o != 3'd0);
    chk("err", err8, o == 3'd7);
    chk("result", res8, exp);
    @(negedge clk);
    chk("done_pulse", done8, 0);
    res_m = exp;
  endtask

  initial begin
    int k;
    bit saw;
    repeat (2) @(negedge clk);
    chk("rst_result", res8, 0);
    chk("rst_done", done8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_err", err8, 0);
    rst_n = 1;
    // add with carry then sub wrapping negative
    run_op(3'd1, 8'd255, 8'd255, 0);
    chk("t1_add", res8, 16'h01FE);
    run_op(3'd5, 8'd3, 8'd5, 0);
    chk("t1_sub", res8, 16'hFFFE);
    // back-to-back single-cycle ops
    @(negedge clk);
    start8 = 1; op8 = 3'd2; a8 = 8'hF0; b8 = 8'h3C;
    @(negedge clk);
    op8 = 3'd3;
    chk("b2b_and_done", done8, 1);
    chk("b2b_and", res8, 16'h0030);
    @(negedge clk);
    op8 = 3'd4;
    chk("b2b_xor_done", done8, 1);
    chk("b2b_xor", res8, 16'h00CC);
    @(negedge clk);
    start8 = 0;
    chk("b2b_or_done", done8, 1);
    chk("b2b_or", res8, 16'h00FC);
    @(negedge clk);
    chk("b2b_end", done8, 0);
    res_m = 16'h00FC;
    // multiply with start noise while busy
    run_op(3'd6, 8'd255, 8'd255, 1);
    chk("t3_mul", res8, 16'hFE01);
    run_op(3'd7, 8'd12, 8'd34, 0);
    run_op(3'd1, 8'd10, 8'd20, 0);
    run_op(3'd0, 8'd99, 8'd1, 0);
    chk("t4_nop_hold", res8, 16'd30);
    // randomized sweep, including edge operands
    for (int i = 0; i < 60; i++) begin
      logic [7:0] ra, rb;
      ra = (i % 7 == 0) ? 8'hFF : 8'($urandom);
      rb = (i % 5 == 0) ? 8'h00 : 8'($urandom);
      run_op(3'($urandom), ra, rb, 1'($urandom));
    end
    // reset during multiply cycle 4
    @(negedge clk);
    start8 = 1; op8 = 3'd6; a8 = 8'd200; b8 = 8'd100;
    @(negedge clk);
    start8 = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_err", err8, 0);
    chk("abort_result", res8, 0);
    @(negedge clk);
    rst_n = 1;
    saw = 0;
    repeat (12) begin
      @(negedge clk);
      saw |= done8;
    end
    chk("abort_no_done", saw, 0);
    res_m = 0;
    run_op(3'd1, 8'd1, 8'd1, 0);
    chk("t5_add", res8, 16'd2);
    // 16-bit multiplier
    @(negedge clk);
    start16 = 1; op16 = 3'd6; a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(negedge clk);
    start16 = 0;
    a16 = 0; b16 = 0;
    k = 0;
    while (!done16 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("w16_latency", k, 16);
    chk("w16_result", res16, 32'hFFFE0001);
    chk("w16_err", err16, 0);
    chk("w16_busy", busy16, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
